// File: rtl/yarvi_me_pkg.sv
// Shared definitions for the yarvi memory stage: funct3 encodings, MMIO timer
// offsets, address classes and the store-side byte-lane helpers.
package yarvi_me_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Word offsets (address bits [3:2]) of the timer registers
  localparam logic [1:0] MMIO_MTIME_LO    = 2'd0;
  localparam logic [1:0] MMIO_MTIME_HI    = 2'd1;
  localparam logic [1:0] MMIO_MTIMECMP_LO = 2'd2;
  localparam logic [1:0] MMIO_MTIMECMP_HI = 2'd3;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_RAM   = 2'd1,
    CLS_MMIO  = 2'd2
  } addr_cls_e;

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3[1:0])
      2'd0:    m = 4'b0001 << a;
      2'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      2'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the LSB-aligned store data across lanes; the mask selects the live ones
  function automatic logic [31:0] lane_align(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3[1:0])
      2'd1:    m = a[0];
      2'd2:    m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/yarvi_store_buffer.sv
// In-order store buffer: FIFO of {word address, lane data, byte mask} with a
// combinational word-address hit query used for load-hit-store stalling.
module yarvi_store_buffer #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 30
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [31:0]       i_push_data,
  input  logic [3:0]        i_push_mask,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_query_addr,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [31:0]       o_head_data,
  output logic [3:0]        o_head_mask,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_hit
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SB_DEPTH);

  logic [ADDR_W-1:0] r_addr [SB_DEPTH];
  logic [31:0]       r_data [SB_DEPTH];
  logic [3:0]        r_mask [SB_DEPTH];
  logic [SB_DEPTH-1:0] r_valid;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              w_do_push;
  logic              w_do_pop;
  logic [CNT_W-1:0]  w_count_nxt;

  assign w_do_pop  = i_pop & ~r_empty;
  assign w_do_push = i_push & (~r_full | w_do_pop);

  // Occupancy after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Pointers, occupancy and entry valid bits; pending entries are discarded on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_valid <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_empty <= (w_count_nxt == CNT_W'(0));
      if (w_do_pop) begin
        r_head           <= r_head + PTR_W'(1);
        r_valid[r_head]  <= 1'b0;
      end
      if (w_do_push) begin
        r_tail           <= r_tail + PTR_W'(1);
        r_valid[r_tail]  <= 1'b1;
      end
    end
  end

  // Entry payload storage
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
      r_mask[r_tail] <= i_push_mask;
    end
  end

  // Any live entry covering the queried word
  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == i_query_addr)) begin
        o_hit = 1'b1;
      end else begin
        o_hit = o_hit;
      end
    end
  end

  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign o_head_mask = r_mask[r_head];
  assign o_full      = r_full;
  assign o_empty     = r_empty;

endmodule

// File: rtl/yarvi_me_sb.sv
// yarvi memory stage with store buffer: byte-lane data RAM, in-order store
// drain, MMIO timer, valid/ready handshake and load-hit-store stalling.
module yarvi_me_sb
  import yarvi_me_pkg::*;
#(
  parameter int          PMSB      = 13,
  parameter int          SB_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE = 32'h4000_0000,
  parameter logic [31:0] RAM_BASE  = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] pc,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_val,
  input  logic        readenable,
  input  logic        writeenable,
  input  logic [2:0]  funct3,
  input  logic [31:0] writedata,
  output logic        me_valid,
  output logic [31:0] me_pc,
  output logic [4:0]  me_wb_rd,
  output logic [31:0] me_wb_val,
  output logic        me_exc_misaligned,
  output logic [31:0] me_exc_mtval,
  output logic        me_timer_interrupt,
  output logic        sb_empty
);

  localparam int WORDS = 1 << (PMSB - 1);

  logic [3:0][7:0] r_ram [WORDS];
  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;

  addr_cls_e       w_cls;
  logic            w_is_ram;
  logic            w_is_mmio;
  logic            w_misal;
  logic            w_ready;
  logic            w_accept;
  logic            w_ram_ld;
  logic            w_push;
  logic            w_pop;
  logic            w_mmio_wr;
  logic            w_full;
  logic            w_empty;
  logic            w_hit;
  logic [29:0]     w_head_addr;
  logic [31:0]     w_head_data;
  logic [3:0]      w_head_mask;
  logic [PMSB-2:0] w_ram_idx;
  logic [PMSB-2:0] w_head_idx;
  logic [31:0]     w_ram_word;
  logic [31:0]     w_mmio_rd;
  logic [31:0]     w_load_val;
  logic            w_unused;

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0] s;
    logic [31:0] r;
    s = w >> {a, 3'b000};
    case (f3)
      F3_LB:   r = {{24{s[7]}}, s[7:0]};
      F3_LH:   r = {{16{s[15]}}, s[15:0]};
      F3_LW:   r = s;
      F3_LBU:  r = {24'h00_0000, s[7:0]};
      F3_LHU:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // Address class decode
  always_comb begin
    if (wb_val[31:PMSB+1] == RAM_BASE[31:PMSB+1]) begin
      w_cls = CLS_RAM;
    end else if ((wb_val & 32'hFFFF_FFF3) == MMIO_BASE) begin
      w_cls = CLS_MMIO;
    end else begin
      w_cls = CLS_OTHER;
    end
  end

  assign w_is_ram  = (w_cls == CLS_RAM);
  assign w_is_mmio = (w_cls == CLS_MMIO);
  assign w_misal   = valid & (readenable | writeenable) & is_misaligned(funct3, wb_val[1:0]);

  assign w_ready  = ~(valid & writeenable & w_is_ram & ~w_misal & w_full)
                  & ~(valid & readenable & w_is_ram & w_hit);
  assign ready    = w_ready;
  // Misaligned ops retire as exceptions even when the port would stall
  assign w_accept = valid & (w_ready | w_misal);

  assign w_ram_ld  = w_accept & readenable & ~w_misal & w_is_ram;
  assign w_push    = w_accept & writeenable & ~readenable & ~w_misal & w_is_ram;
  assign w_mmio_wr = w_accept & writeenable & ~readenable & ~w_misal & w_is_mmio
                   & (funct3 == F3_LW);
  // Accepted RAM traffic owns the port this cycle, so a store burst fills the buffer
  assign w_pop     = ~w_empty & ~w_ram_ld & ~w_push;

  yarvi_store_buffer #(
    .SB_DEPTH (SB_DEPTH),
    .ADDR_W   (30)
  ) u_sb (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_push_addr  (wb_val[31:2]),
    .i_push_data  (lane_align(funct3, writedata)),
    .i_push_mask  (store_mask(funct3, wb_val[1:0])),
    .i_pop        (w_pop),
    .i_query_addr (wb_val[31:2]),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_head_mask  (w_head_mask),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_hit        (w_hit)
  );

  assign w_ram_idx  = wb_val[PMSB:2];
  assign w_head_idx = w_head_addr[PMSB-2:0];
  assign w_ram_word = r_ram[w_ram_idx];
  assign w_unused   = &{1'b0, w_head_addr[29:PMSB-1]};

  // Buffer drain into the RAM lanes
  always_ff @(posedge clock) begin
    if (w_pop) begin
      for (int l = 0; l < 4; l++) begin
        if (w_head_mask[l]) begin
          r_ram[w_head_idx][l] <= w_head_data[l*8 +: 8];
        end
      end
    end
  end

  // Timer register read mux
  always_comb begin
    case (wb_val[3:2])
      MMIO_MTIME_LO:    w_mmio_rd = r_mtime[31:0];
      MMIO_MTIME_HI:    w_mmio_rd = r_mtime[63:32];
      MMIO_MTIMECMP_LO: w_mmio_rd = r_mtimecmp[31:0];
      MMIO_MTIMECMP_HI: w_mmio_rd = r_mtimecmp[63:32];
      default:          w_mmio_rd = 32'h0000_0000;
    endcase
  end

  // Load result per address class
  always_comb begin
    case (w_cls)
      CLS_RAM:  w_load_val = load_align(funct3, wb_val[1:0], w_ram_word);
      CLS_MMIO: w_load_val = (funct3 == F3_LW) ? w_mmio_rd : 32'h0000_0000;
      default:  w_load_val = 32'h0000_0000;
    endcase
  end

  // Timer: a write to one mtime half replaces that cycle's increment
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mtime            <= 64'd0;
      r_mtimecmp         <= 64'hFFFF_FFFF_FFFF_FFFF;
      me_timer_interrupt <= 1'b0;
    end else begin
      if (w_mmio_wr && (wb_val[3:2] == MMIO_MTIME_LO)) begin
        r_mtime <= {r_mtime[63:32], writedata};
      end else if (w_mmio_wr && (wb_val[3:2] == MMIO_MTIME_HI)) begin
        r_mtime <= {writedata, r_mtime[31:0]};
      end else begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (w_mmio_wr && (wb_val[3:2] == MMIO_MTIMECMP_LO)) begin
        r_mtimecmp <= {r_mtimecmp[63:32], writedata};
      end else if (w_mmio_wr && (wb_val[3:2] == MMIO_MTIMECMP_HI)) begin
        r_mtimecmp <= {writedata, r_mtimecmp[31:0]};
      end
      me_timer_interrupt <= (r_mtime >= r_mtimecmp);
    end
  end

  // Result stage register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      me_valid          <= 1'b0;
      me_pc             <= 32'h0000_0000;
      me_wb_rd          <= 5'd0;
      me_wb_val         <= 32'h0000_0000;
      me_exc_misaligned <= 1'b0;
      me_exc_mtval      <= 32'h0000_0000;
    end else if (w_accept) begin
      me_valid          <= ~w_misal;
      me_pc             <= pc;
      me_wb_rd          <= w_misal ? 5'd0 : wb_rd;
      me_wb_val         <= (readenable && !w_misal) ? w_load_val : wb_val;
      me_exc_misaligned <= w_misal;
      if (w_misal) begin
        me_exc_mtval <= wb_val;
      end
    end else begin
      me_valid          <= 1'b0;
      me_wb_rd          <= 5'd0;
      me_exc_misaligned <= 1'b0;
    end
  end

  assign sb_empty = w_empty;

endmodule

// File: tb/tb_yarvi_me_sb.sv
// Directed self-checking bench for yarvi_me_sb.
module tb_yarvi_me_sb;
  import yarvi_me_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] pc = 32'h0000_1000;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_val = 32'h0;
  logic        readenable = 1'b0;
  logic        writeenable = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] writedata = 32'h0;
  logic        me_valid;
  logic [31:0] me_pc;
  logic [4:0]  me_wb_rd;
  logic [31:0] me_wb_val;
  logic        me_exc_misaligned;
  logic [31:0] me_exc_mtval;
  logic        me_timer_interrupt;
  logic        sb_empty;

  int n_chk = 0;
  int n_err = 0;

  yarvi_me_sb dut (
    .clock(clock), .reset_n(reset_n), .valid(valid), .ready(ready), .pc(pc),
    .wb_rd(wb_rd), .wb_val(wb_val), .readenable(readenable), .writeenable(writeenable),
    .funct3(funct3), .writedata(writedata), .me_valid(me_valid), .me_pc(me_pc),
    .me_wb_rd(me_wb_rd), .me_wb_val(me_wb_val), .me_exc_misaligned(me_exc_misaligned),
    .me_exc_mtval(me_exc_mtval), .me_timer_interrupt(me_timer_interrupt), .sb_empty(sb_empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    readenable = 1'b0;
    writeenable = 1'b0;
    repeat (n) step();
  endtask

  // Present one op, hold it until accepted, return with outputs of that op visible
  task automatic op(input logic re, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [4:0] rd, output int stalls);
    pc = pc + 32'd4;
    wb_rd = rd;
    wb_val = addr;
    readenable = re;
    writeenable = we;
    funct3 = f3;
    writedata = wd;
    valid = 1'b1;
    stalls = 0;
    #1;
    while (!ready && stalls < 20) begin
      step();
      stalls++;
    end
    check("accept", {31'd0, ready}, 32'd1);
    step();
    valid = 1'b0;
    readenable = 1'b0;
    writeenable = 1'b0;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    readenable = 1'b0;
    writeenable = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int st;
    int st_sum;
    logic early;
    logic [31:0] words [5];
    #3;
    do_reset();
    check("rst_me_valid", {31'd0, me_valid}, 32'd0);
    check("rst_wb_rd", {27'd0, me_wb_rd}, 32'd0);
    check("rst_exc", {31'd0, me_exc_misaligned}, 32'd0);
    check("rst_irq", {31'd0, me_timer_interrupt}, 32'd0);
    check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);

    // Store, drain, load back
    op(1'b0, 1'b1, F3_LW, 32'h8000_0010, 32'h1122_3344, 5'd3, st);
    check("sw_me_valid", {31'd0, me_valid}, 32'd1);
    check("sw_bypass", me_wb_val, 32'h8000_0010);
    check("sw_sb_busy", {31'd0, sb_empty}, 32'd0);
    idle(1);
    check("drain_sb_empty", {31'd0, sb_empty}, 32'd1);
    op(1'b1, 1'b0, F3_LW, 32'h8000_0010, 32'h0, 5'd7, st);
    check("lw_val", me_wb_val, 32'h1122_3344);
    check("lw_rd", {27'd0, me_wb_rd}, 32'd7);
    check("lw_pc", me_pc, pc);

    // Load-hit-store: sb then lbu/lb back-to-back
    op(1'b0, 1'b1, F3_LB, 32'h8000_0021, 32'h0000_00AB, 5'd0, st);
    op(1'b1, 1'b0, F3_LBU, 32'h8000_0021, 32'h0, 5'd8, st);
    check("lhs_stall", st, 32'd1);
    check("lbu_val", me_wb_val, 32'h0000_00AB);
    op(1'b1, 1'b0, F3_LB, 32'h8000_0021, 32'h0, 5'd9, st);
    check("lb_stall", st, 32'd0);
    check("lb_val", me_wb_val, 32'hFFFF_FFAB);

    // Five stores into a four-entry buffer
    st_sum = 0;
    for (int i = 0; i < 5; i++) begin
      words[i] = 32'hA000_0000 + 32'(i * 32'h0101_0101);
      op(1'b0, 1'b1, F3_LW, 32'h8000_0100 + 32'(4 * i), words[i], 5'd1, st);
      if (i < 4) st_sum += st;
      else check("sw5_stall", st, 32'd1);
    end
    check("sw1to4_stall", st_sum, 32'd0);
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, F3_LW, 32'h8000_0100 + 32'(4 * i), 32'h0, 5'd2, st);
      check($sformatf("burst_rd%0d", i), me_wb_val, words[i]);
    end

    // Sub-word store lanes and halfword loads
    op(1'b0, 1'b1, F3_LW, 32'h8000_0000, 32'hCAFE_F00D, 5'd0, st);
    op(1'b0, 1'b1, F3_LH, 32'h8000_0032, 32'h0000_8001, 5'd0, st);
    op(1'b1, 1'b0, F3_LH, 32'h8000_0032, 32'h0, 5'd4, st);
    check("lh_neg", me_wb_val, 32'hFFFF_8001);
    op(1'b1, 1'b0, F3_LHU, 32'h8000_0032, 32'h0, 5'd4, st);
    check("lhu_val", me_wb_val, 32'h0000_8001);

    // Misaligned accesses
    op(1'b1, 1'b0, F3_LH, 32'h8000_0003, 32'h0, 5'd5, st);
    check("mis_exc", {31'd0, me_exc_misaligned}, 32'd1);
    check("mis_mtval", me_exc_mtval, 32'h8000_0003);
    check("mis_valid", {31'd0, me_valid}, 32'd0);
    check("mis_rd", {27'd0, me_wb_rd}, 32'd0);
    op(1'b0, 1'b1, F3_LH, 32'h8000_0001, 32'h0000_FFFF, 5'd0, st);
    check("mis_sh_exc", {31'd0, me_exc_misaligned}, 32'd1);
    check("mis_sh_noenq", {31'd0, sb_empty}, 32'd1);
    op(1'b1, 1'b0, F3_LW, 32'h8000_0000, 32'h0, 5'd6, st);
    check("mis_ram_kept", me_wb_val, 32'hCAFE_F00D);
    check("exc_clear", {31'd0, me_exc_misaligned}, 32'd0);

    // Other-class and bypass
    op(1'b0, 1'b1, F3_LW, 32'h1000_0000, 32'h5555_5555, 5'd0, st);
    check("other_st_drop", {31'd0, sb_empty}, 32'd1);
    op(1'b1, 1'b0, F3_LW, 32'h1000_0000, 32'h0, 5'd6, st);
    check("other_ld_zero", me_wb_val, 32'h0000_0000);
    op(1'b0, 1'b0, F3_LW, 32'h1234_5678, 32'h0, 5'd10, st);
    check("bypass_val", me_wb_val, 32'h1234_5678);
    check("bypass_rd", {27'd0, me_wb_rd}, 32'd10);

    // Timer compare at 100
    do_reset();
    op(1'b0, 1'b1, F3_LW, 32'h4000_0008, 32'd100, 5'd0, st);
    op(1'b0, 1'b1, F3_LW, 32'h4000_000C, 32'd0, 5'd0, st);
    early = 1'b0;
    for (int k = 3; k <= 100; k++) begin
      step();
      if (me_timer_interrupt) early = 1'b1;
    end
    check("irq_not_early", {31'd0, early}, 32'd0);
    step();
    check("irq_rise", {31'd0, me_timer_interrupt}, 32'd1);
    op(1'b1, 1'b0, F3_LW, 32'h4000_0000, 32'h0, 5'd11, st);
    check("mtime_rd", me_wb_val, 32'd101);
    op(1'b1, 1'b0, F3_LW, 32'h4000_0008, 32'h0, 5'd11, st);
    check("mtimecmp_rd", me_wb_val, 32'd100);
    op(1'b1, 1'b0, F3_LHU, 32'h4000_0008, 32'h0, 5'd11, st);
    check("mmio_sub_ld", me_wb_val, 32'd0);

    // Reset discards buffered stores
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b1, F3_LW, 32'h8000_0200 + 32'(4 * i), 32'hB0B0_0000 + 32'(i), 5'd0, st);
    end
    idle(4);
    check("pre_sb_empty", {31'd0, sb_empty}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b1, F3_LW, 32'h8000_0200 + 32'(4 * i), 32'hDEAD_0000 + 32'(i), 5'd0, st);
    end
    check("buffered", {31'd0, sb_empty}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("async_sb_empty", {31'd0, sb_empty}, 32'd1);
    check("async_me_valid", {31'd0, me_valid}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 1'b0, F3_LW, 32'h8000_0200 + 32'(4 * i), 32'h0, 5'd12, st);
      check($sformatf("discard%0d", i), me_wb_val, 32'hB0B0_0000 + 32'(i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
